// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/address typedefs and the memory arbiter state encoding.
package cpu_types_pkg;

    localparam int CPU_WORD_W = 32;
    localparam int CPU_ADDR_W = 32;

    typedef logic [CPU_WORD_W-1:0] word_t;
    typedef logic [CPU_ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE,
        IACC,
        DACC,
        RECOV
    } arb_state_t;

    // Width of a counter that must hold max_val, never narrower than 4 bits.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Clearable, enabled up-counter; with SAT set it stops at MAX, otherwise it wraps.
module mem_wait_counter #(
    parameter int W   = 4,
    parameter int MAX = 15,
    parameter bit SAT = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] LIMIT = W'(MAX);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en && (!SAT || cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data requests beat instruction fetches, one-cycle hit pulses.
// Define ARB_PERF_EN to add icount/dcount/stall_cycles performance counters.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    input  logic              halt,
    output logic              ihit,
    output logic [WORD_W-1:0] iload,
    output logic              dhit,
    output logic [WORD_W-1:0] dload,
    output logic [ADDR_W-1:0] ramaddr,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ram_ready,
    output logic              err_timeout
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]       icount,
    output logic [31:0]       dcount,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int                WAIT_W   = cnt_width(WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

    arb_state_t        state;
    logic              in_acc;
    logic              waiting;
    logic [WAIT_W-1:0] wait_cnt;

    assign in_acc  = (state == IACC) || (state == DACC);
    assign waiting = in_acc && !ram_ready;

    // Strobes follow the granted requester directly; it holds its request until the hit.
    always_comb begin
        ramaddr  = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramstore = '0;
        case (state)
            IACC: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
            end
            DACC: begin
                ramaddr  = daddr;
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramstore = dstore;
            end
            default: ;
        endcase
    end

    // Cleared while idle so every access starts counting from zero.
    mem_wait_counter #(
        .W   (WAIT_W),
        .MAX (WAIT_MAX),
        .SAT (1'b1)
    ) u_wait (
        .clk   (CLK),
        .rst_n (nRST),
        .clr   (state == IDLE),
        .en    (waiting),
        .cnt   (wait_cnt)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= IDLE;
            ihit        <= 1'b0;
            dhit        <= 1'b0;
            iload       <= '0;
            dload       <= '0;
            err_timeout <= 1'b0;
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            if (wait_cnt == WAIT_LIM) err_timeout <= 1'b1;
            case (state)
                IDLE: begin
                    if (dREN || dWEN)      state <= DACC;
                    else if (iREN && !halt) state <= IACC;
                end
                IACC: begin
                    if (ram_ready) begin
                        iload <= ramload;
                        ihit  <= 1'b1;
                        state <= RECOV;
                    end
                end
                DACC: begin
                    if (ram_ready) begin
                        if (dREN) dload <= ramload;
                        dhit  <= 1'b1;
                        state <= RECOV;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_PERF_EN
    mem_wait_counter #(
        .W   (32),
        .MAX (WAIT_MAX),
        .SAT (1'b0)
    ) u_stall (
        .clk   (CLK),
        .rst_n (nRST),
        .clr   (1'b0),
        .en    (waiting),
        .cnt   (stall_cycles)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            icount <= '0;
            dcount <= '0;
        end else begin
            if (state == IACC && ram_ready) icount <= icount + 32'd1;
            if (state == DACC && ram_ready) dcount <= dcount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus directed and random stimulus.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int WAIT_MAX = 15;

    logic  CLK = 1'b0;
    logic  nRST = 1'b0;
    logic  iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, halt = 1'b0, ram_ready = 1'b0;
    addr_t iaddr = '0, daddr = '0;
    word_t dstore = '0, ramload = '0;

    logic  ihit, dhit, ramREN, ramWEN, err_timeout;
    word_t iload, dload, ramstore;
    addr_t ramaddr;

    int n_chk = 0, n_fail = 0, cyc_no = 0;

    mem_arbiter #(.WORD_W(32), .ADDR_W(32), .WAIT_MAX(WAIT_MAX)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .halt(halt), .ihit(ihit), .iload(iload),
        .dhit(dhit), .dload(dload), .ramaddr(ramaddr), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready), .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc_no++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc_no);
        end
    endtask

    // Transaction model: owner of the in-flight access (0 none, 1 instr, 2 data),
    // wait cycles of that access, and the hit/load/error results it has produced.
    int    owner = 0, waits = 0;
    bit    m_ihit = 0, m_dhit = 0, m_err = 0, started = 0;
    word_t m_iload = '0, m_dload = '0;

    always @(posedge CLK) begin
        bit ni, nd;
        ni = 0;
        nd = 0;
        if (!nRST) begin
            owner = 0; waits = 0; m_err = 0; m_iload = '0; m_dload = '0; started = 1;
        end else begin
            if (waits >= WAIT_MAX) m_err = 1;
            if (owner != 0) begin
                if (ram_ready) begin
                    if (owner == 1) begin ni = 1; m_iload = ramload; end
                    else begin nd = 1; if (dREN) m_dload = ramload; end
                    owner = 0;
                end else begin
                    waits++;
                end
            end else if (!m_ihit && !m_dhit) begin
                waits = 0;
                if (dREN || dWEN)       owner = 2;
                else if (iREN && !halt) owner = 1;
            end
        end
        m_ihit = ni;
        m_dhit = nd;
    end

    always @(negedge CLK) begin
        logic  eren, ewen;
        addr_t ea;
        word_t es;
        if (started) begin
            eren = 0; ewen = 0; ea = '0; es = '0;
            if (owner == 1) begin eren = 1; ea = iaddr; end
            else if (owner == 2) begin eren = dREN; ewen = dWEN; ea = daddr; es = dstore; end
            chk("m_ramREN", ramREN, eren);
            chk("m_ramWEN", ramWEN, ewen);
            chk("m_ramaddr", ramaddr, ea);
            chk("m_ramstore", ramstore, es);
            chk("m_ihit", ihit, m_ihit);
            chk("m_dhit", dhit, m_dhit);
            chk("m_iload", iload, m_iload);
            chk("m_dload", dload, m_dload);
            chk("m_err", err_timeout, m_err);
            chk("hit_excl", ihit & dhit, 0);
        end
    end

    task automatic cyc();
        @(posedge CLK); #1;
    endtask

    task automatic nedge();
        @(negedge CLK); #1;
    endtask

    task automatic wait_hit(input bit is_d, input int limit, output int at);
        at = -1;
        for (int k = 0; k < limit; k++) begin
            nedge();
            if ((is_d ? dhit : ihit) === 1'b1) begin at = cyc_no; break; end
        end
        n_chk++;
        if (at < 0) begin
            n_fail++;
            $display("FAIL %s: no hit within %0d cycles", is_d ? "dhit_wait" : "ihit_wait", limit);
        end
    endtask

    initial begin
        int t_d, t_i, t;
        bit slow;

        // Reset held with a fetch pending, then released.
        nRST = 0; iREN = 1; iaddr = 32'h40;
        cyc(); cyc(); nedge();
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ihit", ihit, 0);
        chk("rst_dhit", dhit, 0);
        chk("rst_err", err_timeout, 0);
        nRST = 1;
        cyc(); nedge();
        chk("rel_ramREN", ramREN, 1);
        chk("rel_ramaddr", ramaddr, 32'h40);

        // Reset in the middle of the access: no hit may follow.
        ram_ready = 1; ramload = 32'h12345678; nRST = 0; iREN = 0;
        cyc(); nRST = 1;
        for (int k = 0; k < 3; k++) begin
            nedge();
            chk("abandon_ihit", ihit, 0);
            chk("abandon_iload", iload, 0);
        end

        // Plain fetch: hit lands on cycle 3.
        cyc(); iREN = 1; iaddr = 32'h40; ram_ready = 1; ramload = 32'h8C220004;
        nedge(); chk("fetch_c1_ihit", ihit, 0);
        cyc(); nedge(); chk("fetch_c2_ihit", ihit, 0); chk("fetch_c2_ramREN", ramREN, 1);
        cyc(); nedge(); chk("fetch_c3_ihit", ihit, 1); chk("fetch_iload", iload, 32'h8C220004);
        iREN = 0;
        cyc(); nedge(); chk("fetch_c4_ihit", ihit, 0);

        // Simultaneous requests: data first, fetch three cycles after the data hit.
        iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100; ramload = 32'h11112222;
        wait_hit(1, 20, t_d); dREN = 0;
        wait_hit(0, 20, t_i); iREN = 0;
        chk("prio_gap", t_i - t_d, 3);
        chk("prio_dload", dload, 32'h11112222);
        chk("prio_iload", iload, 32'h11112222);

        // Write with three wait cycles.
        ram_ready = 0; dWEN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF; ramload = 32'h55555555;
        cyc(); nedge();
        for (int k = 0; k < 4; k++) begin
            cyc(); ram_ready = (k == 3); nedge();
            chk("wr_ramWEN", ramWEN, 1);
            chk("wr_ramstore", ramstore, 32'hDEADBEEF);
            chk("wr_ramaddr", ramaddr, 32'h200);
        end
        cyc(); nedge();
        chk("wr_dhit", dhit, 1);
        chk("wr_dload_kept", dload, 32'h11112222);
        dWEN = 0; ram_ready = 0;

        // Halt blocks fetches but not data reads.
        halt = 1; iREN = 1; iaddr = 32'h80;
        for (int k = 0; k < 10; k++) begin
            cyc(); nedge(); chk("halt_ramREN", ramREN, 0);
        end
        dREN = 1; daddr = 32'h300; ram_ready = 1; ramload = 32'hCAFE0001;
        wait_hit(1, 20, t); chk("halt_dload", dload, 32'hCAFE0001);
        dREN = 0; halt = 0;
        wait_hit(0, 20, t); chk("unhalt_iload", iload, 32'hCAFE0001);
        iREN = 0;

        // Timeout: flag rises after WAIT_MAX+1 wait cycles and sticks.
        ram_ready = 0; dREN = 1; daddr = 32'h400; ramload = 32'h0F0F0F0F;
        cyc(); cyc();
        repeat (WAIT_MAX) cyc();
        nedge(); chk("to_err_early", err_timeout, 0);
        cyc(); nedge(); chk("to_err_set", err_timeout, 1);
        ram_ready = 1;
        wait_hit(1, 5, t);
        chk("to_dload", dload, 32'h0F0F0F0F);
        dREN = 0; ram_ready = 0; iREN = 1; iaddr = 32'h500;
        cyc(); nedge(); chk("to_err_sticky", err_timeout, 1);
        cyc(); nedge(); chk("to_iacc_ramREN", ramREN, 1);
        nRST = 0; ram_ready = 1;
        cyc(); nRST = 1; iREN = 0;
        for (int k = 0; k < 3; k++) begin
            nedge(); chk("rst_acc_ihit", ihit, 0); chk("rst_acc_err", err_timeout, 0);
        end

        // Random traffic against the model.
        slow = 0;
        for (int n = 0; n < 4000; n++) begin
            cyc();
            if (n % 500 == 0) slow = ~slow;
            nRST = ($urandom_range(0, 499) != 0);
            if (m_ihit) iREN = 0;
            if (m_dhit) begin dREN = 0; dWEN = 0; end
            if (!iREN && $urandom_range(0, 3) == 0) begin
                iREN = 1; iaddr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dREN && !dWEN && $urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 1) dREN = 1; else dWEN = 1;
                daddr = $urandom & 32'hFFFF_FFFC; dstore = $urandom;
            end
            if ($urandom_range(0, 19) == 0) halt = ~halt;
            ram_ready = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 9) < 6);
            ramload = $urandom;
        end
        nRST = 1;
        cyc(); nedge();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port RAM arbiter between the fetch stage (instruction reads) and the memory stage (data reads/writes).
- Produces the one-cycle ihit/dhit pulses consumed by the pipeline hazard unit, together with the returned load words.
- Sits between the datapath request lines and the RAM port. Data requests take priority over instruction requests.
- Halt suppresses new instruction fetches.

Parameters:
- WORD_W, 32, data word width.
- ADDR_W, 32, byte address width.
- WAIT_MAX, 15, RAM wait cycles before err_timeout is raised; must be at least 1.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  synchronous active-low reset, sampled on the rising edge of CLK.
- iREN  input  1  instruction read request; held until ihit.
- iaddr  input  ADDR_W  instruction address.
- dREN  input  1  data read request; held until dhit.
- dWEN  input  1  data write request; held until dhit. dREN and dWEN are never both set.
- daddr  input  ADDR_W  data address.
- dstore  input  WORD_W  write data.
- halt  input  1  processor halted; blocks new instruction grants.
- ihit  output  1  one-cycle pulse: iload is valid.
- iload  output  WORD_W  registered instruction word.
- dhit  output  1  one-cycle pulse: read data valid, or write complete.
- dload  output  WORD_W  registered read data.
- ramaddr  output  ADDR_W  RAM address.
- ramREN  output  1  RAM read strobe.
- ramWEN  output  1  RAM write strobe.
- ramstore  output  WORD_W  RAM write data.
- ramload  input  WORD_W  RAM read data; valid when ram_ready=1.
- ram_ready  input  1  RAM completes the current access this cycle.
- err_timeout  output  1  sticky: an access waited more than WAIT_MAX cycles.

Behaviour:
- Reset (nRST=0 at a rising edge of CLK): all outputs are 0 and the state is IDLE. A reset mid-access abandons the access; no hit is issued for it.
- States:
  - IDLE: no RAM strobes.
    - dREN|dWEN -> DACC.
    - else iREN & ~halt -> IACC.
    - else stay in IDLE.
    - A data request arriving while an instruction request is pending wins.
  - IACC:
    - ramREN=1, ramaddr=iaddr.
    - On ram_ready: register iload<=ramload, pulse ihit next cycle, go to RECOV.
  - DACC:
    - ramaddr=daddr, ramREN=dREN, ramWEN=dWEN, ramstore=dstore.
    - On ram_ready: on a read, register dload<=ramload; pulse dhit next cycle; go to RECOV.
  - RECOV:
    - Hit pulse cycle; no RAM strobes. Gives the requester one cycle to drop or change its request.
    - Always returns to IDLE; re-arbitration happens in IDLE on the next cycle.
- Latency: minimum 3 cycles from request to hit (IDLE, ACC with ram_ready=1, RECOV). Each RAM wait cycle adds 1.
- A granted access is never preempted. A data request arriving during IACC waits for the instruction access to finish.
- ihit and dhit are never high in the same cycle. Each is high for exactly one cycle per completed access.
- iload and dload hold their values until overwritten by the next access of the same kind.
- RAM strobes and address are combinational from state and request inputs. They are stable throughout ACC as long as the requester holds its request, which is required.
- halt=1 in IDLE: instruction requests are ignored; data requests are still serviced. halt rising during IACC does not abort the fetch.
- Wait counter:
  - 4-bit minimum, saturating.
  - Cleared on entry to IACC or DACC; increments each ACC cycle with ram_ready=0.
  - Reaching WAIT_MAX sets err_timeout. err_timeout clears only on reset. The access keeps waiting.

Optional Feature:
- Macro: ARB_PERF_EN.
- When defined, adds outputs:
  - icount (32): completed instruction accesses.
  - dcount (32): completed data accesses.
  - stall_cycles (32): cycles spent in IACC or DACC with ram_ready=0.
- All three counters are cleared by reset and wrap at 2^32.
- When undefined, these ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- Shared cpu_types_pkg gets:
  - word_t and addr_t typedefs.
  - arb_state_t enum {IDLE, IACC, DACC, RECOV}.
- One natural sub-module: mem_wait_counter (saturating counter, clear/enable inputs, WAIT_MAX compare). It is reused by the arbiter for err_timeout and for stall_cycles.

Test Plan:
- Reset: hold nRST=0 two cycles with iREN=1 -> ramREN=0, ihit=0, dhit=0, err_timeout=0. Release nRST -> ramREN=1 with ramaddr=iaddr one cycle later.
- Instruction fetch: iREN=1, iaddr=0x40, ram_ready=1 on the first ACC cycle, ramload=0x8C220004 -> ihit pulses exactly at cycle 3, iload=0x8C220004.
- Priority: iREN=1 and dREN=1 together, daddr=0x100 -> DACC first and dhit. Next IDLE -> IACC, then ihit. No overlapping hits.
- Write with waits: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, ram_ready low for 3 cycles -> ramWEN=1 with ramstore stable for 4 cycles, then dhit. dload unchanged.
- Halt: halt=1, iREN=1 -> no ramREN for 10 cycles. dREN=1 during halt is still serviced with dhit.
- Timeout: ram_ready held 0 for WAIT_MAX+1 cycles -> err_timeout=1 and stays 1 after the later ram_ready. A reset mid-ACC yields no hit.
